// File: rtl/l2_refill_responder_pkg.sv
// ----------------------------------------------------------------------------
// L2_pkg: shared widths, FSM state type and line-store entry type for the
// L2 instruction-refill responder.
//   LADDR_W : line-address width (address[31:6])
//   L2INUM  : L2 set-index bits (2^L2INUM sets)
//   TAG_W   : stored tag width (line address above the set index)
//   L21BUS  : line width toward L1 and from memory
// ----------------------------------------------------------------------------
package L2_pkg;

  localparam int TNUM    = 21;
  localparam int INUM    = 26 - TNUM;
  localparam int LADDR_W = TNUM + INUM;
  localparam int L2INUM  = 7;
  localparam int L2SETS  = 1 << L2INUM;
  localparam int TAG_W   = LADDR_W - L2INUM;
  localparam int L21BUS  = 512;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    HIT_WAIT = 3'd2,
    MEM_REQ  = 3'd3,
    RESP     = 3'd4
  } l2_resp_state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [L21BUS-1:0] data;
  } line_entry_t;

  // Set index of a line address.
  function automatic logic [L2INUM-1:0] idx_of(input logic [LADDR_W-1:0] a);
    return a[L2INUM-1:0];
  endfunction

  // Tag portion of a line address.
  function automatic logic [TAG_W-1:0] tag_of(input logic [LADDR_W-1:0] a);
    return a[LADDR_W-1:L2INUM];
  endfunction

endpackage

// File: rtl/l2_refill_responder_line_store.sv
// ----------------------------------------------------------------------------
// l2_line_store: direct-mapped valid/tag/data arrays.
//   clk, rst            : clock, async active-high reset (clears valid bits)
//   rd_idx_i/rd_entry_o : combinational read port
//   wr_en_i, wr_idx_i,
//   wr_tag_i, wr_data_i : write port; a write sets the valid bit of the set
// ----------------------------------------------------------------------------
module l2_line_store
  import L2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [L2INUM-1:0] rd_idx_i,
  output line_entry_t       rd_entry_o,
  input  logic              wr_en_i,
  input  logic [L2INUM-1:0] wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [L21BUS-1:0] wr_data_i
);

  logic [L2SETS-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [L2SETS];
  logic [L21BUS-1:0] data_q [L2SETS];

  // Valid bits: the only state that reset must clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays: meaningless while the set's valid bit is clear.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Read port.
  always_comb begin
    rd_entry_o.valid = valid_q[rd_idx_i];
    rd_entry_o.tag   = tag_q[rd_idx_i];
    rd_entry_o.data  = data_q[rd_idx_i];
  end

endmodule

// File: rtl/l2_refill_responder.sv
// ----------------------------------------------------------------------------
// l2_refill_responder: services L1 instruction-cache line refills from a
// direct-mapped L2 line store, fetching from memory on a miss.
//   clk, rst                     : clock, async active-high reset
//   read_L1_L2, address_L1_L2    : L1 refill request (level) and line address
//   ready_L2_L1, read_data_L2_L1 : one-cycle response pulse and line
//   read_L2_M, address_L2_M      : memory fetch request (level) and address
//   ready_M_L2, read_data_M_L2   : memory data valid and line
// Optional feature macro L2_REFILL_STATS_EN adds saturating 32-bit
// hit_cnt_L2 / miss_cnt_L2 outputs.
// ----------------------------------------------------------------------------
module l2_refill_responder
  import L2_pkg::*;
#(
  parameter int HIT_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_L1_L2,
  input  logic [LADDR_W-1:0] address_L1_L2,
  output logic               ready_L2_L1,
  output logic [L21BUS-1:0]  read_data_L2_L1,
  output logic               read_L2_M,
  output logic [LADDR_W-1:0] address_L2_M,
  input  logic               ready_M_L2,
  input  logic [L21BUS-1:0]  read_data_M_L2
`ifdef L2_REFILL_STATS_EN
  ,
  output logic [31:0]        hit_cnt_L2,
  output logic [31:0]        miss_cnt_L2
`endif
);

  // Counter covers HIT_WAIT cycles; entering HIT_WAIT one edge after LOOKUP
  // means it is loaded with HIT_LAT-2 and expires on zero.
  localparam int CNT_W = (HIT_LAT > 2) ? $clog2(HIT_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HIT_LAT - 2);

  l2_resp_state_t     state_q, state_d;
  logic [LADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic [L21BUS-1:0]  rdata_q, rdata_d;
  logic               read_m_q, read_m_d;
  logic [LADDR_W-1:0] addr_m_q, addr_m_d;
  line_entry_t        rd_entry_s;
  logic               hit_s;
  logic               wr_en_s;
`ifdef L2_REFILL_STATS_EN
  logic [31:0]        hit_cnt_q, hit_cnt_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;
`endif

  l2_line_store u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (idx_of(addr_q)),
    .rd_entry_o (rd_entry_s),
    .wr_en_i    (wr_en_s),
    .wr_idx_i   (idx_of(addr_q)),
    .wr_tag_i   (tag_of(addr_q)),
    .wr_data_i  (read_data_M_L2)
  );

  assign hit_s = rd_entry_s.valid && (rd_entry_s.tag == tag_of(addr_q));

  // Next-state and registered-output logic of the refill FSM.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    rdata_d  = rdata_q;
    read_m_d = read_m_q;
    addr_m_d = addr_m_q;
    wr_en_s  = 1'b0;
`ifdef L2_REFILL_STATS_EN
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (read_L1_L2) begin
          addr_d  = address_L1_L2;
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (hit_s) begin
          cnt_d   = CNT_LOAD;
          state_d = HIT_WAIT;
`ifdef L2_REFILL_STATS_EN
          if (hit_cnt_q != 32'hFFFF_FFFF) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            hit_cnt_d = hit_cnt_q;
          end
`endif
        end else begin
          // Registered request: read_L2_M is high for every MEM_REQ cycle.
          read_m_d = 1'b1;
          addr_m_d = addr_q;
          state_d  = MEM_REQ;
`ifdef L2_REFILL_STATS_EN
          if (miss_cnt_q != 32'hFFFF_FFFF) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
          end else begin
            miss_cnt_d = miss_cnt_q;
          end
`endif
        end
      end
      HIT_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          rdata_d = rd_entry_s.data;
          ready_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MEM_REQ: begin
        if (ready_M_L2) begin
          rdata_d  = read_data_M_L2;
          wr_en_s  = 1'b1;
          read_m_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = RESP;
        end else begin
          state_d = MEM_REQ;
        end
      end
      RESP: begin
        // ready_q is high for this single cycle only.
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        read_m_d = 1'b0;
      end
    endcase
  end

  // FSM state, latched address and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      read_m_q   <= 1'b0;
      addr_m_q   <= '0;
`ifdef L2_REFILL_STATS_EN
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      read_m_q   <= read_m_d;
      addr_m_q   <= addr_m_d;
`ifdef L2_REFILL_STATS_EN
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
`endif
    end
  end

  assign ready_L2_L1     = ready_q;
  assign read_data_L2_L1 = rdata_q;
  assign read_L2_M       = read_m_q;
  assign address_L2_M    = addr_m_q;
`ifdef L2_REFILL_STATS_EN
  assign hit_cnt_L2  = hit_cnt_q;
  assign miss_cnt_L2 = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l2_refill_responder.sv
// ----------------------------------------------------------------------------
// Testbench for l2_refill_responder: table of directed refills, hand-written
// reset / noise sequences, and two randomized passes checked against a
// set-level cache model and an address-hash memory model.
// ----------------------------------------------------------------------------
module tb_l2_refill_responder;
  import L2_pkg::*;

  localparam int HIT_LAT_TB = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               read_L1_L2;
  logic [LADDR_W-1:0] address_L1_L2;
  logic               ready_L2_L1;
  logic [L21BUS-1:0]  read_data_L2_L1;
  logic               read_L2_M;
  logic [LADDR_W-1:0] address_L2_M;
  logic               ready_M_L2;
  logic [L21BUS-1:0]  read_data_M_L2;
`ifdef L2_REFILL_STATS_EN
  logic [31:0]        hit_cnt_L2;
  logic [31:0]        miss_cnt_L2;
`endif

  always #5 clk = ~clk;

  l2_refill_responder #(.HIT_LAT(HIT_LAT_TB)) dut (
    .clk             (clk),
    .rst             (rst),
    .read_L1_L2      (read_L1_L2),
    .address_L1_L2   (address_L1_L2),
    .ready_L2_L1     (ready_L2_L1),
    .read_data_L2_L1 (read_data_L2_L1),
    .read_L2_M       (read_L2_M),
    .address_L2_M    (address_L2_M),
    .ready_M_L2      (ready_M_L2),
    .read_data_M_L2  (read_data_M_L2)
`ifdef L2_REFILL_STATS_EN
    ,
    .hit_cnt_L2      (hit_cnt_L2),
    .miss_cnt_L2     (miss_cnt_L2)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Reference model: which line address each set currently holds.
  bit                 m_valid [L2SETS];
  logic [LADDR_W-1:0] m_line  [L2SETS];

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [L21BUS-1:0] got,
                            input logic [L21BUS-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Memory contents: a fixed hash of the line address.
  function automatic logic [L21BUS-1:0] mem_line(input logic [LADDR_W-1:0] a);
    logic [L21BUS-1:0] r;
    logic [31:0] base;
    base = {6'd0, a} * 32'h9E37_79B1;
    for (int i = 0; i < L21BUS / 32; i++) begin
      r[i*32 +: 32] = base ^ (32'h0101_0101 * i) ^ {6'd0, a};
    end
    return r;
  endfunction

  function automatic bit model_hit(input logic [LADDR_W-1:0] a);
    int s;
    s = int'(a) % L2SETS;
    return m_valid[s] && (m_line[s] == a);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < L2SETS; s++) m_valid[s] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // One refill: request, play memory if asked, check latency/data/address.
  task automatic do_req(input logic [LADDR_W-1:0] a, input int mem_delay,
                        input bit exp_hit, input bit noise, input string nm);
    int n, mem_cnt, ready_m_at, s;
    bit done, saw_mem;
    @(negedge clk);
    read_L1_L2 = 1'b1;
    address_L1_L2 = a;
    n = 0; mem_cnt = 0; ready_m_at = -10; done = 1'b0; saw_mem = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (ready_M_L2) begin
        ready_M_L2 = 1'b0;
        read_data_M_L2 = '0;
      end
      if (noise) address_L1_L2 = LADDR_W'($urandom);
      if (ready_L2_L1) begin
        if (exp_hit) check_int({nm, " hit latency"}, n, HIT_LAT_TB);
        else         check_int({nm, " miss latency"}, n, ready_m_at + 1);
        check_line({nm, " data"}, read_data_L2_L1, mem_line(a));
        check_int({nm, " memory used"}, int'(saw_mem), int'(!exp_hit));
        read_L1_L2 = 1'b0;
        done = 1'b1;
      end else if (read_L2_M) begin
        if (!saw_mem) check_int({nm, " mem addr"}, int'(address_L2_M), int'(a));
        saw_mem = 1'b1;
        if (mem_cnt == mem_delay) begin
          ready_M_L2 = 1'b1;
          read_data_M_L2 = mem_line(address_L2_M);
          ready_m_at = n;
        end
        mem_cnt++;
      end
      n++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: no ready_L2_L1 within 40 cycles", nm);
      read_L1_L2 = 1'b0;
      ready_M_L2 = 1'b0;
    end
    @(negedge clk);
    check_int({nm, " pulse width"}, int'(ready_L2_L1), 0);
    s = int'(a) % L2SETS;
    m_valid[s] = 1'b1;
    m_line[s] = a;
    if (exp_hit) exp_hits++;
    else exp_misses++;
  endtask

  typedef struct {
    logic [LADDR_W-1:0] addr;
    int                 delay;
    bit                 exp_hit;
    bit                 noise;
  } vec_t;

  vec_t vecs [10];
  logic [LADDR_W-1:0] raddr [64];

  initial begin
    bit saw_ready;

    vecs[0] = '{26'h0000040, 5, 1'b0, 1'b0};  // cold miss
    vecs[1] = '{26'h0000040, 0, 1'b1, 1'b0};  // hit
    vecs[2] = '{26'h00000C0, 2, 1'b0, 1'b0};  // conflict, same set 0x40
    vecs[3] = '{26'h0000040, 1, 1'b0, 1'b0};  // evicted -> miss again
    vecs[4] = '{26'h0000040, 0, 1'b1, 1'b1};  // hit, address noise in HIT_WAIT
    vecs[5] = '{26'h00000C0, 0, 1'b0, 1'b0};  // memory answers first MEM_REQ cycle
    vecs[6] = '{26'h3FFFFFF, 3, 1'b0, 1'b0};  // top set, all-ones tag
    vecs[7] = '{26'h3FFFFFF, 0, 1'b1, 1'b1};
    vecs[8] = '{26'h000007F, 0, 1'b0, 1'b1};  // same set, tag 0, noise during miss
    vecs[9] = '{26'h3FFFFFF, 1, 1'b0, 1'b0};

    rst = 1'b1;
    read_L1_L2 = 1'b0;
    address_L1_L2 = '0;
    ready_M_L2 = 1'b0;
    read_data_M_L2 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_int("reset ready_L2_L1", int'(ready_L2_L1), 0);
    check_line("reset read_data_L2_L1", read_data_L2_L1, '0);
    check_int("reset read_L2_M", int'(read_L2_M), 0);
    check_int("reset address_L2_M", int'(address_L2_M), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].addr, vecs[i].delay, vecs[i].exp_hit, vecs[i].noise,
             $sformatf("vec%0d", i));
    end

    // Stray memory-ready while idle must change nothing.
    @(negedge clk);
    ready_M_L2 = 1'b1;
    read_data_M_L2 = {16{32'hDEAD_BEEF}};
    @(negedge clk);
    ready_M_L2 = 1'b0;
    check_int("idle noise ready_L2_L1", int'(ready_L2_L1), 0);
    check_int("idle noise read_L2_M", int'(read_L2_M), 0);
    do_req(26'h3FFFFFF, 0, 1'b1, 1'b0, "after idle noise");

    // Reset in MEM_REQ with memory answering in the same cycle.
    @(negedge clk);
    read_L1_L2 = 1'b1;
    address_L1_L2 = 26'h00002A0;
    repeat (2) @(negedge clk);
    check_int("midmiss read_L2_M before reset", int'(read_L2_M), 1);
    ready_M_L2 = 1'b1;
    read_data_M_L2 = mem_line(26'h00002A0);
    #2 rst = 1'b1;
    #1;
    check_int("midmiss read_L2_M drops", int'(read_L2_M), 0);
    check_int("midmiss ready_L2_L1", int'(ready_L2_L1), 0);
    @(negedge clk);
    ready_M_L2 = 1'b0;
    read_L1_L2 = 1'b0;
    rst = 1'b0;
    model_reset();
    saw_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ready_L2_L1) saw_ready = 1'b1;
    end
    check_int("midmiss no response", int'(saw_ready), 0);
    do_req(26'h00002A0, 1, 1'b0, 1'b0, "after reset 2A0");
    do_req(26'h3FFFFFF, 0, 1'b0, 1'b0, "after reset 3FFFFFF");

    // Randomized back-to-back refills, two passes over the same addresses.
    for (int i = 0; i < 64; i++) raddr[i] = LADDR_W'($urandom);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 64; i++) begin
        do_req(raddr[i], int'($urandom_range(0, 3)), model_hit(raddr[i]),
               (p == 1) && ($urandom_range(0, 1) == 1), $sformatf("rnd p%0d i%0d", p, i));
      end
    end

`ifdef L2_REFILL_STATS_EN
    check_int("stats hits", int'(hit_cnt_L2), exp_hits);
    check_int("stats misses", int'(miss_cnt_L2), exp_misses);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
